// File: rtl/pause_dim_ctrl.sv
// Pause/screen-dim controller: merges user button and external pause requests,
// drives the core pause line and fades RGB in frame-aligned steps after idle time.
module pause_dim_ctrl #(
    parameter int R_W         = 3,
    parameter int G_W         = 3,
    parameter int B_W         = 2,
    parameter int N_SRC       = 1,
    parameter int DIM_CYCLES  = 480000000,
    parameter int FADE_MAX    = 1,
    parameter int FRAME_ALIGN = 1
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             pause_btn,
    input  logic [N_SRC-1:0] pause_req,
    input  logic             vblank,
    input  logic [R_W-1:0]   r_in,
    input  logic [G_W-1:0]   g_in,
    input  logic [B_W-1:0]   b_in,
    output logic [R_W-1:0]   r_out,
    output logic [G_W-1:0]   g_out,
    output logic [B_W-1:0]   b_out,
    output logic             pause,
    output logic             user_paused,
    output logic [1:0]       fade_lvl
);

    localparam int              CNT_W    = $clog2(DIM_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIM_CYCLES);
    localparam logic [1:0]      FADE_TOP = 2'(FADE_MAX);

    logic             btn_q;
    logic             vblank_q;
    logic             toggle;
    logic             toggle_nxt;
    logic             up_nxt;
    logic             btn_edge;
    logic             vb_rise;
    logic [CNT_W-1:0] idle_cnt;

    assign btn_edge = pause_btn & ~btn_q;
    assign vb_rise  = vblank & ~vblank_q;

    // A button edge coinciding with a vblank rise is loaded in that same cycle.
    always_comb begin
        toggle_nxt = toggle ^ btn_edge;
        if (FRAME_ALIGN == 0)
            up_nxt = toggle_nxt;
        else
            up_nxt = vb_rise ? toggle_nxt : user_paused;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            btn_q       <= 1'b0;
            vblank_q    <= 1'b0;
            toggle      <= 1'b0;
            user_paused <= 1'b0;
            pause       <= 1'b0;
        end else begin
            btn_q       <= pause_btn;
            vblank_q    <= vblank;
            toggle      <= toggle_nxt;
            user_paused <= up_nxt;
            pause       <= (|pause_req) | user_paused;
        end
    end

    // Idle time only accrues under user pause; external holds never dim.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            idle_cnt <= '0;
        else if (!user_paused)
            idle_cnt <= '0;
        else if (idle_cnt != CNT_MAX)
            idle_cnt <= idle_cnt + CNT_W'(1);
    end

    // Fade steps only once the counter already sits at its limit before the vblank rise.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            fade_lvl <= 2'd0;
        else if (!user_paused)
            fade_lvl <= 2'd0;
        else if (idle_cnt == CNT_MAX && vb_rise && fade_lvl < FADE_TOP)
            fade_lvl <= fade_lvl + 2'd1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= '0;
            g_out <= '0;
            b_out <= '0;
        end else begin
            r_out <= r_in >> fade_lvl;
            g_out <= g_in >> fade_lvl;
            b_out <= b_in >> fade_lvl;
        end
    end

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Bench for pause_dim_ctrl: directed scenarios plus randomized traffic checked
// against an event-level model (pause durations and frames elapsed while dimmed).
module tb_pause_dim_ctrl;

    localparam int R_W = 3, G_W = 3, B_W = 2, N_SRC = 2;
    localparam int DIM = 100, FMAX = 2;
    localparam int FRAME = 40, VB_START = 36;

    logic             clk_sys = 1'b0;
    logic             reset_n = 1'b1;
    logic             pause_btn = 1'b0;
    logic [N_SRC-1:0] pause_req = '0;
    logic             vblank = 1'b0;
    logic [R_W-1:0]   r_in = '0;
    logic [G_W-1:0]   g_in = '0;
    logic [B_W-1:0]   b_in = '0;
    logic [R_W-1:0]   r_out;
    logic [G_W-1:0]   g_out;
    logic [B_W-1:0]   b_out;
    logic             pause;
    logic             user_paused;
    logic [1:0]       fade_lvl;

    pause_dim_ctrl #(
        .R_W(R_W), .G_W(G_W), .B_W(B_W), .N_SRC(N_SRC),
        .DIM_CYCLES(DIM), .FADE_MAX(FMAX), .FRAME_ALIGN(1)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .pause_btn(pause_btn),
        .pause_req(pause_req), .vblank(vblank),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .pause(pause), .user_paused(user_paused), .fade_lvl(fade_lvl)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0, errors = 0;
    int frame_pos = 0;
    bit rand_rgb = 0;

    // Model: tracks how long user pause has lasted and how many frames began after the idle limit.
    bit m_btn_q, m_vb_q, m_tog, m_up, m_pause, last_rise;
    int m_idle, m_dim_frames, m_r, m_g, m_b;

    function automatic int fade_exp();
        return (m_dim_frames > FMAX) ? FMAX : m_dim_frames;
    endfunction

    task automatic model_reset();
        m_btn_q = 0; m_vb_q = 0; m_tog = 0; m_up = 0; m_pause = 0; last_rise = 0;
        m_idle = 0; m_dim_frames = 0; m_r = 0; m_g = 0; m_b = 0;
    endtask

    task automatic tick();
        bit edge_, rise;
        int f;
        if (rand_rgb) begin
            r_in = R_W'($urandom);
            g_in = G_W'($urandom);
            b_in = B_W'($urandom);
        end
        vblank = (frame_pos % FRAME) >= VB_START;
        frame_pos++;
        edge_ = pause_btn && !m_btn_q;
        rise  = vblank && !m_vb_q;
        f = fade_exp();
        m_r = int'(r_in) >> f;
        m_g = int'(g_in) >> f;
        m_b = int'(b_in) >> f;
        m_pause = (pause_req != 0) || m_up;
        if (m_up) begin
            if (m_idle >= DIM && rise) m_dim_frames++;
            m_idle++;
        end else begin
            m_idle = 0;
            m_dim_frames = 0;
        end
        if (edge_) m_tog = !m_tog;
        if (rise) m_up = m_tog;
        m_btn_q = pause_btn;
        m_vb_q = vblank;
        last_rise = rise;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            checks++;
            if (pause !== m_pause || user_paused !== m_up || fade_lvl !== 2'(fade_exp()) ||
                r_out !== R_W'(m_r) || g_out !== G_W'(m_g) || b_out !== B_W'(m_b)) begin
                errors++;
                $display("FAIL model_cycle t=%0t: pause=%b up=%b fade=%0d rgb=%0d/%0d/%0d, want %b %b %0d %0d/%0d/%0d",
                         $time, pause, user_paused, fade_lvl, r_out, g_out, b_out,
                         m_pause, m_up, fade_exp(), m_r, m_g, m_b);
            end
        end
    endtask

    task automatic test_reset();
        r_in = 3'd7; g_in = 3'd7; b_in = 2'd3;
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({r_out, g_out, b_out, pause, user_paused, fade_lvl} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {r_out, g_out, b_out, pause, user_paused, fade_lvl});
        end
        @(posedge clk_sys); @(posedge clk_sys); #1;
        reset_n = 1'b1;
        model_reset();
        tick();
        checks++;
        if (r_out !== 3'd7 || g_out !== 3'd7 || b_out !== 2'd3) begin
            errors++;
            $display("FAIL reset_release_rgb: got %0d/%0d/%0d, want 7/7/3", r_out, g_out, b_out);
        end
    endtask

    task automatic test_frame_entry();
        logic up_obs [50];
        logic p_obs [50];
        int first_up;
        frame_pos = 5;
        pause_btn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            up_obs[i] = user_paused;
            p_obs[i] = pause;
        end
        pause_btn = 1'b0;
        first_up = -1;
        for (int i = 0; i < 50; i++)
            if (first_up < 0 && up_obs[i] === 1'b1) first_up = i;
        checks++;
        if (first_up != VB_START - 5) begin
            errors++;
            $display("FAIL entry_at_vblank: user_paused first at tick %0d, want %0d", first_up, VB_START - 5);
        end else begin
            checks++;
            if (p_obs[first_up] !== 1'b0 || p_obs[first_up + 1] !== 1'b1 || p_obs[first_up - 1] !== 1'b0) begin
                errors++;
                $display("FAIL entry_pause_latency: pause %b,%b,%b around entry, want 0,0,1",
                         p_obs[first_up - 1], p_obs[first_up], p_obs[first_up + 1]);
            end
        end
        run(100);
        checks++;
        if (user_paused !== 1'b1) begin
            errors++;
            $display("FAIL held_button_single_toggle: user_paused=%b, want 1", user_paused);
        end
    endtask

    task automatic wait_fade(input logic [1:0] lvl, input string name);
        int n = 0;
        while (fade_lvl !== lvl && n < 400) begin
            run(1);
            n++;
        end
        checks++;
        if (fade_lvl !== lvl) begin
            errors++;
            $display("FAIL %s: fade_lvl=%0d, want %0d", name, fade_lvl, lvl);
        end
    endtask

    task automatic test_dim();
        r_in = 3'd7; g_in = 3'd7; b_in = 2'd3;
        wait_fade(2'd1, "dim_step1");
        run(1);
        checks++;
        if (r_out !== 3'd3 || g_out !== 3'd3 || b_out !== 2'd1) begin
            errors++;
            $display("FAIL dim_rgb1: got %0d/%0d/%0d, want 3/3/1", r_out, g_out, b_out);
        end
        wait_fade(2'd2, "dim_step2");
        run(1);
        checks++;
        if (r_out !== 3'd1 || g_out !== 3'd1 || b_out !== 2'd0) begin
            errors++;
            $display("FAIL dim_rgb2: got %0d/%0d/%0d, want 1/1/0", r_out, g_out, b_out);
        end
        run(3 * FRAME);
        checks++;
        if (fade_lvl !== 2'd2) begin
            errors++;
            $display("FAIL dim_saturate: fade_lvl=%0d, want 2", fade_lvl);
        end
    endtask

    task automatic test_unpause();
        int n = 0;
        frame_pos = 10;
        pause_btn = 1'b1; run(1);
        pause_btn = 1'b0; run(1);
        while (user_paused !== 1'b0 && n < 100) begin
            run(1);
            n++;
        end
        checks++;
        if (user_paused !== 1'b0 || fade_lvl !== 2'd2 || !last_rise) begin
            errors++;
            $display("FAIL unpause_at_vblank: up=%b fade=%0d rise=%b, want 0 2 1", user_paused, fade_lvl, last_rise);
        end
        run(1);
        checks++;
        if (fade_lvl !== 2'd0) begin
            errors++;
            $display("FAIL unpause_restore: fade_lvl=%0d, want 0", fade_lvl);
        end
        run(1);
        checks++;
        if (r_out !== 3'd7 || g_out !== 3'd7 || b_out !== 2'd3) begin
            errors++;
            $display("FAIL unpause_rgb: got %0d/%0d/%0d, want 7/7/3", r_out, g_out, b_out);
        end
    endtask

    task automatic test_ext_req();
        frame_pos = 3;
        pause_req = 2'b10;
        run(1);
        checks++;
        if (pause !== 1'b1 || user_paused !== 1'b0 || last_rise) begin
            errors++;
            $display("FAIL ext_req_immediate: pause=%b up=%b, want 1 0", pause, user_paused);
        end
        run(499);
        checks++;
        if (fade_lvl !== 2'd0 || pause !== 1'b1) begin
            errors++;
            $display("FAIL ext_req_no_dim: fade=%0d pause=%b, want 0 1", fade_lvl, pause);
        end
        pause_req = 2'b00;
        run(1);
        checks++;
        if (pause !== 1'b0) begin
            errors++;
            $display("FAIL ext_req_release: pause=%b, want 0", pause);
        end
    endtask

    task automatic test_edge_at_vblank();
        frame_pos = 20;
        while (frame_pos != VB_START) run(1);
        pause_btn = 1'b1;
        run(1);
        checks++;
        if (user_paused !== 1'b1) begin
            errors++;
            $display("FAIL edge_with_vblank: user_paused=%b, want 1", user_paused);
        end
        pause_btn = 1'b0;
        run(5);
    endtask

    task automatic test_random();
        rand_rgb = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 250) == 0) pause_btn = 1'b1;
            else if ($urandom_range(0, 3) == 0) pause_btn = 1'b0;
            if ($urandom_range(0, 400) == 0) pause_req = N_SRC'($urandom);
            run(1);
        end
        pause_btn = 1'b0;
        pause_req = '0;
        run(2);
        rand_rgb = 0;
    endtask

    task automatic test_reset_mid_fade();
        if (!m_tog) begin
            pause_btn = 1'b1; run(1);
            pause_btn = 1'b0;
        end
        r_in = 3'd7; g_in = 3'd7; b_in = 2'd3;
        wait_fade(2'd2, "mid_fade_setup");
        pause_req = 2'b01;
        run(1);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({r_out, g_out, b_out, pause, user_paused, fade_lvl} !== '0) begin
            errors++;
            $display("FAIL reset_mid_fade: got %b, want all zero",
                     {r_out, g_out, b_out, pause, user_paused, fade_lvl});
        end
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        model_reset();
        run(1);
        checks++;
        if (pause !== 1'b1 || user_paused !== 1'b0 || fade_lvl !== 2'd0) begin
            errors++;
            $display("FAIL reset_release_req: pause=%b up=%b fade=%0d, want 1 0 0", pause, user_paused, fade_lvl);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_frame_entry();
        test_dim();
        test_unpause();
        test_ext_req();
        test_edge_at_vblank();
        test_random();
        test_reset_mid_fade();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
